// File: rtl/shift_left_seq.sv
// Iterative one-bit-per-clock left shifter with a start/done handshake.
// Define SHL_ROTATE_EN to honour the rot input (rotate-left); otherwise logical shift only.
module shift_left_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   shifts,
   input  logic             rot,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] acc, acc_nx, acc_shl, result_nx;
   logic [SHW-1:0]   cnt, cnt_nx;
   logic             busy_nx, done_nx;
   logic             fill;

`ifdef SHL_ROTATE_EN
   logic rot_q, rot_nx;

   // Rotate feeds the MSB back into bit 0; logical mode zero-fills.
   assign fill = rot_q & acc[WIDTH-1];

   always_ff @(posedge clk) begin
      if (clr) rot_q <= 1'b0;
      else     rot_q <= rot_nx;
   end
`else
   logic [1:0] unused_bits;

   assign unused_bits = {rot, acc[WIDTH-1]};
   assign fill        = 1'b0;
`endif

   assign acc_shl = {acc[WIDTH-2:0], fill};

   // State register
   always_ff @(posedge clk) begin
      if (clr) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start) state_nx = (shifts == '0) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt == SHW'(1)) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath and output next values; Result only changes on the edge entering DONE
   always_comb begin
      acc_nx    = acc;
      cnt_nx    = cnt;
      result_nx = Result;
`ifdef SHL_ROTATE_EN
      rot_nx    = rot_q;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               acc_nx = B;
               cnt_nx = shifts;
`ifdef SHL_ROTATE_EN
               rot_nx = rot;
`endif
               if (shifts == '0) result_nx = B;
            end
         end
         S_SHIFT: begin
            acc_nx = acc_shl;
            cnt_nx = cnt - SHW'(1);
            if (cnt == SHW'(1)) result_nx = acc_shl;
         end
         default: begin
            acc_nx = acc;
         end
      endcase
      busy_nx = (state_nx != S_IDLE);
      done_nx = (state_nx == S_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (clr) begin
         acc    <= '0;
         cnt    <= '0;
         Result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         acc    <= acc_nx;
         cnt    <= cnt_nx;
         Result <= result_nx;
         busy   <= busy_nx;
         done   <= done_nx;
      end
   end

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: timeline reference model plus directed literal cases.
// Honours SHL_ROTATE_EN the same way the design does.
module tb_shift_left_seq;

   logic        clk = 1'b0;
   logic        clr, start, rot;
   logic [31:0] B;
   logic [4:0]  shifts;
   logic        busy, done;
   logic [31:0] Result;

   int nchk  = 0;
   int npass = 0;

   shift_left_seq #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .clr(clr), .start(start), .B(B), .shifts(shifts), .rot(rot),
      .busy(busy), .done(done), .Result(Result)
   );

   always #5 clk = ~clk;

   // Reference: what a shift/rotate by n produces, computed arithmetically
   function automatic logic [31:0] ref_shl(input logic [31:0] b, input int n, input logic r);
      logic r_eff;
`ifdef SHL_ROTATE_EN
      r_eff = r;
`else
      r_eff = 1'b0;
`endif
      if (n == 0) return b;
      if (r_eff)  return (b << n) | (b >> (32 - n));
      return b << n;
   endfunction

   // Timeline model: an accepted request at edge T finishes at edge T+n; next accept at T+n+2
   int          cyc     = 0;
   int          t_done  = -10;
   int          free_at = 0;
   bit          active  = 0;
   bit          exp_busy = 0, exp_done = 0;
   logic [31:0] pend    = '0;
   logic [31:0] exp_res = '0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (clr) begin
         active  = 0;
         exp_res = '0;
         free_at = cyc + 1;
      end else if (start && cyc >= free_at) begin
         active  = 1;
         t_done  = cyc + int'(shifts);
         pend    = ref_shl(B, int'(shifts), rot);
         free_at = t_done + 2;
      end
      exp_busy = active && (cyc <= t_done);
      exp_done = active && (cyc == t_done);
      if (exp_done) exp_res = pend;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("busy",   32'(busy), 32'(exp_busy));
         check("done",   32'(done), 32'(exp_done));
         check("Result", Result,    exp_res);
      end
   end

   task automatic run_op(input logic [31:0] b, input logic [4:0] n, input logic r,
                         input logic [31:0] exp, input string name);
      int lat;
      bit seen;
      B = b; shifts = n; rot = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat  = 1;
      seen = 0;
      while (!seen && lat <= 40) begin
         if (done) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!seen) begin
         nchk++;
         $display("FAIL %s timeout: no done within 40 cycles", name);
      end else begin
         check({name, " result"},  Result,   exp);
         check({name, " latency"}, 32'(lat), 32'((n == 5'd0) ? 1 : int'(n) + 1));
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int guard;
      clr = 1'b1; start = 1'b0; B = '0; shifts = '0; rot = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset busy",   32'(busy), 32'd0);
      check("reset done",   32'(done), 32'd0);
      check("reset Result", Result,    32'h0000_0000);
      clr = 1'b0;
      @(negedge clk);

      run_op(32'hA5A5_A5A5, 5'd1,  1'b0, 32'h4B4B_4B4A, "shl1");
      run_op(32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800, "shl8");
      run_op(32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, "shl31 one");
      run_op(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000, "shl31 ones");
      run_op(32'hFFFF_FFFF, 5'd0,  1'b0, 32'hFFFF_FFFF, "shl0");
`ifdef SHL_ROTATE_EN
      run_op(32'h8000_0001, 5'd4,  1'b1, 32'h0000_0018, "rol4 a");
      run_op(32'hDEAD_BEEF, 5'd4,  1'b1, 32'hEADB_EEFD, "rol4 b");
`else
      run_op(32'h8000_0001, 5'd4,  1'b1, 32'h0000_0010, "rot ignored a");
      run_op(32'hDEAD_BEEF, 5'd4,  1'b1, 32'hEADB_EEF0, "rot ignored b");
`endif

      // Back-to-back with start held high
      B = 32'hFFFF_FFFF; shifts = 5'd0; rot = 1'b0; start = 1'b1;
      @(negedge clk);
      check("b2b zero done",   32'(done), 32'd1);
      check("b2b zero result", Result,    32'hFFFF_FFFF);
      B = 32'h1234_5678; shifts = 5'd8;
      @(negedge clk);
      @(negedge clk);
      check("b2b hold result", Result, 32'hFFFF_FFFF);
      guard = 0;
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b0;
      if (!done) begin
         nchk++;
         $display("FAIL b2b timeout: no done within 40 cycles");
      end else check("b2b second result", Result, 32'h3456_7800);
      repeat (4) @(negedge clk);

      // Clear in the middle of an operation
      B = 32'h8765_4321; shifts = 5'd16; rot = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr busy",   32'(busy), 32'd0);
      check("clr done",   32'(done), 32'd0);
      check("clr Result", Result,    32'h0000_0000);
      repeat (20) @(negedge clk);
      run_op(32'h0000_000F, 5'd3, 1'b0, 32'h0000_0078, "after clr");

      // Randomised traffic, including stray starts and occasional clears
      repeat (500) begin
         clr    = ($urandom_range(0, 59) == 0);
         start  = ($urandom_range(0, 2) == 0);
         B      = $urandom;
         shifts = 5'($urandom);
         rot    = 1'($urandom);
         @(negedge clk);
      end
      clr = 1'b0; start = 1'b0;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
